tff_toggle_arbiter: RTL

- Shares one WIDTH-bit toggle register among NREQ requesters. The register is a bank of T flip-flops: each bit flips when its toggle input is 1.
- Each requester submits a toggle mask through a valid/ready handshake.
- A round-robin arbiter picks one requester at a time and applies its mask as q <= q ^ mask.
- Sits between software-visible requesters and the T-FF bank. It is the only writer of the bank.

---
 rtl/tff_pkg.sv | 12 +
 rtl/rr_pick.sv | 30 +++
 rtl/tff_toggle_arbiter.sv | 76 +++++++
 3 files changed

// File: rtl/tff_pkg.sv
// rtl/tff_pkg.sv - shared state encoding and default sizes for the toggle arbiter
package tff_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_APPLY = 1'b1
  } state_t;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker; scans last+1, last+2, ... modulo NREQ
module rr_pick
  import tff_pkg::*;
#(
  parameter  int NREQ = DEF_NREQ,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [IW-1:0]   winner,
  output logic            any
);

  logic [IW-1:0] idx;

  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = '0;
    // i == NREQ wraps back to last itself, so it has lowest priority
    for (int i = 1; i <= NREQ; i++) begin
      idx = IW'((int'(last) + i) % NREQ);
      if (!any && req[idx]) begin
        any    = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/tff_toggle_arbiter.sv
// rtl/tff_toggle_arbiter.sv - round-robin arbiter applying requester masks to a shared T-FF bank
module tff_toggle_arbiter
  import tff_pkg::*;
#(
  parameter  int NREQ  = DEF_NREQ,
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int CNTW  = 16,
  localparam int IW    = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_mask,
  output logic [NREQ-1:0]       req_ready,
  output logic [WIDTH-1:0]      q,
  output logic [IW-1:0]         grant_id,
  output logic                  busy,
  output logic [CNTW-1:0]       op_count
);

  state_t           state, state_nx;
  logic [IW-1:0]    last;
  logic [IW-1:0]    winner;
  logic             any;
  logic [WIDTH-1:0] mask_r;
  logic [WIDTH-1:0] mask_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign mask_arr[g] = req_mask[g*WIDTH +: WIDTH];
  end

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req    (req_valid),
    .last   (last),
    .winner (winner),
    .any    (any)
  );

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (any) state_nx = ST_APPLY;
      ST_APPLY: state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  assign busy = (state == ST_APPLY);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state     <= ST_IDLE;
      last      <= IW'(NREQ - 1);
      grant_id  <= '0;
      mask_r    <= '0;
      q         <= '0;
      req_ready <= '0;
      op_count  <= '0;
    end else begin
      state     <= state_nx;
      req_ready <= '0;
      // mask is captured at grant so later changes by the requester are ignored
      if (state == ST_IDLE && any) begin
        grant_id <= winner;
        mask_r   <= mask_arr[winner];
      end
      if (state == ST_APPLY) begin
        q         <= q ^ mask_r;
        req_ready <= NREQ'(1) << grant_id;
        op_count  <= op_count + CNTW'(1);
        last      <= grant_id;
      end
    end
  end

endmodule
